// File: rtl/pad_pkg.sv
// Shared types and constants for the padding-path packet sequencer.
// The state enum, the select bundle and the fixed slot numbers that the
// FSM and the counters agree on all live here.
package pad_pkg;

    // Width of one mux output word and the bits it adds to the message length.
    localparam int WORD_W    = 64;
    localparam int WORD_BITS = 64;

    // Slot counter width; a block is 16 words, so slots are 0..15.
    localparam int IDX_W      = 4;
    // Last slot of a block: this is where the length word must land.
    localparam int IDX_LAST   = 15;
    // Slot just before the length slot: a pad or zero here hands over to LEN.
    localparam int IDX_PRELEN = 14;

    // Sequencer phases: message forwarding, pad word, zero fill, length word.
    typedef enum logic [1:0] {
        MSG  = 2'd0,
        PAD  = 2'd1,
        ZERO = 2'd2,
        LEN  = 2'd3
    } pad_state_e;

    // Mux select bundle; at most one field is ever set.
    typedef struct packed {
        logic mgln;
        logic zero;
        logic pad;
    } pad_sel_t;

    // Decode a state into its mux selects (all zero while forwarding data).
    function automatic pad_sel_t sel_of_state(input pad_state_e st);
        pad_sel_t s;
        s = '0;
        case (st)
            PAD:     s.pad  = 1'b1;
            ZERO:    s.zero = 1'b1;
            LEN:     s.mgln = 1'b1;
            default: s      = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pad_word_cnt.sv
// Slot and length counters for the padding sequencer.
// word_idx counts every transferred word and wraps naturally at the block
// boundary. msg_len accumulates WORD_BITS per message word and is cleared
// when the length word leaves; clear wins over increment.
module pad_word_cnt
    import pad_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idx_inc,
    input  logic             len_inc,
    input  logic             len_clr,
    output logic [IDX_W-1:0] word_idx,
    output logic [LEN_W-1:0] msg_len
);

    // Slot counter: advances on every transfer, wraps 15 -> 0 by width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx <= '0;
        end else if (idx_inc) begin
            word_idx <= word_idx + 1'b1;
        end
    end

    // Bit-length accumulator: +WORD_BITS per message word, wraps mod 2^LEN_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_len <= '0;
        end else if (len_clr) begin
            msg_len <= '0;
        end else if (len_inc) begin
            msg_len <= msg_len + LEN_W'(WORD_BITS);
        end
    end

endmodule

// File: rtl/pkt_pad_ctrl.sv
// Sequencer for the 64-bit packet mux in the padding path.
// Forwards message words with zero latency, then steers the mux through
// one pad word, zero fill and a final length word so that the length lands
// in the last slot of a block.
//
// Handshake: a word moves on any cycle with out_valid && out_ready. In MSG
// the source handshake is passed straight through (out_valid = in_valid,
// in_ready = out_ready); in every other state the controller itself is the
// source (out_valid = 1, in_ready = 0). Selects and out_valid only change
// on a transfer, so they hold while out_ready is low.
module pkt_pad_ctrl
    import pad_pkg::*;
#(
    parameter int WORDS_PER_BLK = 16,
    parameter int LEN_W         = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             pad_pkt,
    output logic             zero_pkt,
    output logic             mgln_pkt,
    output logic [LEN_W-1:0] msg_len,
    output logic [3:0]       word_idx,
    output logic             blk_last,
    output logic             msg_done
);

    pad_state_e state_q;
    pad_state_e state_d;
    pad_sel_t   sel;
    logic       xfer;
    logic       at_prelen;

    assign xfer      = out_valid && out_ready;
    assign at_prelen = (word_idx == IDX_W'(IDX_PRELEN));

    // Counters: every transfer advances the slot; only message words add
    // to the length; the length word's departure clears it for the next message.
    pad_word_cnt #(
        .LEN_W (LEN_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .idx_inc  (xfer),
        .len_inc  (xfer && (state_q == MSG)),
        .len_clr  (xfer && (state_q == LEN)),
        .word_idx (word_idx),
        .msg_len  (msg_len)
    );

    // State register; reset abandons any partial message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MSG;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: phases only advance on a transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MSG: begin
                if (xfer && in_last) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                // Pad in slot 14 leaves exactly the length slot; anywhere
                // else (including slot 15, which wraps) needs zero fill.
                if (xfer) begin
                    state_d = at_prelen ? LEN : ZERO;
                end
            end
            ZERO: begin
                if (xfer && at_prelen) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (xfer) begin
                    state_d = MSG;
                end
            end
            default: state_d = MSG;
        endcase
    end

    // Output decode: selects from state, handshake pass-through in MSG,
    // and both handshake outputs forced low while reset is asserted.
    always_comb begin
        sel       = sel_of_state(state_q);
        out_valid = 1'b1;
        in_ready  = 1'b0;
        if (state_q == MSG) begin
            out_valid = in_valid;
            in_ready  = out_ready;
        end
        if (!rst_n) begin
            out_valid = 1'b0;
            in_ready  = 1'b0;
        end
    end

    assign pad_pkt  = sel.pad;
    assign zero_pkt = sel.zero;
    assign mgln_pkt = sel.mgln;
    assign blk_last = out_valid && (word_idx == 4'(WORDS_PER_BLK - 1));

    // Completion pulse: one cycle after the length word is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_done <= 1'b0;
        end else begin
            msg_done <= xfer && (state_q == LEN);
        end
    end

endmodule

// File: tb/tb_pkt_pad_ctrl.sv
// Directed bench for pkt_pad_ctrl. Expected output words come from a small
// reference model of the padding layout pushed into exp_q; each cycle the
// handshake outputs, msg_done, blk_last and the presented word are compared.
module tb_pkt_pad_ctrl;

    localparam int W = 71;  // {mgln, zero, pad, idx[3:0], len[63:0]}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        pad_pkt;
    logic        zero_pkt;
    logic        mgln_pkt;
    logic [63:0] msg_len;
    logic [3:0]  word_idx;
    logic        blk_last;
    logic        msg_done;

    int n_vec  = 0;
    int n_fail = 0;
    int m_idx  = 0;
    logic [W-1:0] exp_q[$];

    // Clock / reset block
    always #5 clk = ~clk;

    pkt_pad_ctrl #(
        .WORDS_PER_BLK (16),
        .LEN_W         (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pad_pkt   (pad_pkt),
        .zero_pkt  (zero_pkt),
        .mgln_pkt  (mgln_pkt),
        .msg_len   (msg_len),
        .word_idx  (word_idx),
        .blk_last  (blk_last),
        .msg_done  (msg_done)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] enc(input logic [2:0] sel, input int idx, input logic [63:0] len);
        logic [3:0] i4;
        i4 = idx[3:0];
        return {sel, i4, len};
    endfunction

    // Reference layout: data words, pad, zeros until slot 14, length in slot 15.
    task automatic expect_msg(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(enc(3'b000, m_idx, 64'd0));
            m_idx = (m_idx + 1) % 16;
        end
        exp_q.push_back(enc(3'b001, m_idx, 64'd0));
        m_idx = (m_idx + 1) % 16;
        while (m_idx != 15) begin
            exp_q.push_back(enc(3'b010, m_idx, 64'd0));
            m_idx = (m_idx + 1) % 16;
        end
        exp_q.push_back(enc(3'b100, 15, 64'(n * 64)));
        m_idx = 0;
    endtask

    // Driver + per-cycle checks. Sends n1 then n2 words (n2=0: single message),
    // random out_ready if rnd, stops after max_xfer transfers if nonzero.
    task automatic run(input string tag, input int n1, input int n2, input bit rnd, input int max_xfer);
        int a = n1;
        int b = n2;
        int cyc = 0;
        int xfers = 0;
        logic exp_done = 1'b0;
        logic exp_ov, exp_ir, xfer, is_data, nxt_done;
        logic [W-1:0] front, obs;
        expect_msg(n1);
        if (n2 > 0) expect_msg(n2);
        while (cyc < 800) begin
            @(negedge clk);
            in_valid  = (a > 0) || (b > 0);
            in_last   = (a > 0) ? (a == 1) : (b == 1);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            front   = (exp_q.size() > 0) ? exp_q[0] : '0;
            is_data = (exp_q.size() == 0) || (front[70:68] == 3'b000);
            exp_ov  = (exp_q.size() == 0) ? 1'b0 : (is_data ? in_valid : 1'b1);
            exp_ir  = is_data ? out_ready : 1'b0;
            check({tag, ".out_valid"}, W'(out_valid), W'(exp_ov));
            check({tag, ".in_ready"}, W'(in_ready), W'(exp_ir));
            check({tag, ".msg_done"}, W'(msg_done), W'(exp_done));
            check({tag, ".blk_last"}, W'(blk_last), W'(exp_ov && (front[67:64] == 4'd15)));
            if (exp_ov) begin
                obs = {mgln_pkt, zero_pkt, pad_pkt, word_idx, (mgln_pkt ? msg_len : 64'd0)};
                check({tag, ".word"}, obs, front);
            end
            xfer     = exp_ov && out_ready;
            nxt_done = xfer && front[70];
            if (xfer) begin
                void'(exp_q.pop_front());
                xfers++;
            end
            if (in_valid && exp_ir) begin
                if (a > 0) a--;
                else b--;
            end
            exp_done = nxt_done;
            cyc++;
            if (max_xfer > 0 && xfers >= max_xfer) break;
            if (exp_q.size() == 0 && !exp_done) break;
        end
        if (max_xfer == 0) begin
            check({tag, ".drain"}, W'(exp_q.size()), W'(0));
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            #1;
            check({tag, ".done_drop"}, W'(msg_done), W'(0));
            check({tag, ".idle_valid"}, W'(out_valid), W'(0));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".out_valid"}, W'(out_valid), W'(0));
        check({tag, ".in_ready"}, W'(in_ready), W'(0));
        check({tag, ".selects"}, W'({mgln_pkt, zero_pkt, pad_pkt}), W'(0));
        check({tag, ".word_idx"}, W'(word_idx), W'(0));
        check({tag, ".msg_len"}, W'(msg_len), W'(0));
        check({tag, ".msg_done"}, W'(msg_done), W'(0));
    endtask

    initial begin
        // Reset with source pushing: handshake outputs must stay low.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst0");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // 1. single-word message
        run("t1", 1, 0, 1'b0, 0);
        // 2. 14 words: pad in slot 14, no zero fill
        run("t2", 14, 0, 1'b0, 0);
        // 3. 15 words: pad in slot 15, full extra block
        run("t3", 15, 0, 1'b0, 0);
        // 4. 16 words: pad opens block 2
        run("t4", 16, 0, 1'b0, 0);
        // 5. backpressure on the single-word message, and a longer one
        run("t5", 1, 0, 1'b1, 0);
        run("t5b", 5, 0, 1'b1, 0);

        // 6. reset in the middle of zero fill
        run("t6a", 1, 0, 1'b0, 4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("t6rst");
        exp_q.delete();
        m_idx = 0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b1;
        run("t6b", 2, 0, 1'b0, 0);

        // 7. back-to-back messages, source never idles between them
        run("t7", 3, 2, 1'b0, 0);
        run("t7r", 2, 4, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
